// File: rtl/mem_dispatcher_if.sv
// Signal bundle between the memory dispatcher and its fetcher, LSU and RAM/IO neighbours.
interface mem_dispatcher_if #(
    parameter int ADDR_W = 32
);
    logic              in_flush_enable;
    logic              in_fetcher_requesting;
    logic [ADDR_W-1:0] in_fetcher_addr;
    logic              out_fetcher_req_enable;
    logic              out_fetcher_data_enable;
    logic [31:0]       out_fetcher_inst;
    logic              in_lsu_requesting;
    logic              in_lsu_rw;
    logic [2:0]        in_lsu_size;
    logic [ADDR_W-1:0] in_lsu_addr;
    logic [31:0]       in_lsu_wdata;
    logic              out_lsu_req_enable;
    logic              out_lsu_data_enable;
    logic [31:0]       out_lsu_rdata;
    logic [ADDR_W-1:0] out_mem_addr;
    logic [7:0]        out_mem_dout;
    logic              out_mem_wr;
    logic [7:0]        in_mem_din;
    logic              in_io_buffer_full;

    modport master (
        input  in_flush_enable,
        input  in_fetcher_requesting,
        input  in_fetcher_addr,
        output out_fetcher_req_enable,
        output out_fetcher_data_enable,
        output out_fetcher_inst,
        input  in_lsu_requesting,
        input  in_lsu_rw,
        input  in_lsu_size,
        input  in_lsu_addr,
        input  in_lsu_wdata,
        output out_lsu_req_enable,
        output out_lsu_data_enable,
        output out_lsu_rdata,
        output out_mem_addr,
        output out_mem_dout,
        output out_mem_wr,
        input  in_mem_din,
        input  in_io_buffer_full
    );

    modport slave (
        output in_flush_enable,
        output in_fetcher_requesting,
        output in_fetcher_addr,
        input  out_fetcher_req_enable,
        input  out_fetcher_data_enable,
        input  out_fetcher_inst,
        output in_lsu_requesting,
        output in_lsu_rw,
        output in_lsu_size,
        output in_lsu_addr,
        output in_lsu_wdata,
        input  out_lsu_req_enable,
        input  out_lsu_data_enable,
        input  out_lsu_rdata,
        input  out_mem_addr,
        input  out_mem_dout,
        input  out_mem_wr,
        output in_mem_din,
        output in_io_buffer_full
    );
endinterface

// File: rtl/mem_dispatcher.sv
// Serialises fetch and LSU requests onto the single byte-wide RAM port.
// LSU has strict priority; in-flight fetches are abandoned on flush.
module mem_dispatcher #(
    parameter int         ADDR_W     = 32,
    parameter logic [1:0] IO_BASE_HI = 2'b11
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_rdy,
    mem_dispatcher_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic              fslot_vld_r, fslot_vld_s;
    logic [ADDR_W-1:0] fslot_addr_r, fslot_addr_s;
    logic              lslot_vld_r, lslot_vld_s;
    logic              lslot_rw_r, lslot_rw_s;
    logic [2:0]        lslot_len_r, lslot_len_s;
    logic [ADDR_W-1:0] lslot_addr_r, lslot_addr_s;
    logic [31:0]       lslot_wdata_r, lslot_wdata_s;
    logic              cur_fetch_r, cur_fetch_s;
    logic [ADDR_W-1:0] cur_base_r, cur_base_s;
    logic [2:0]        cur_len_r, cur_len_s;
    logic [31:0]       cur_wdata_r, cur_wdata_s;
    logic [2:0]        idx_r, idx_s;
    logic [31:0]       asm_r, asm_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [7:0]        mem_dout_r, mem_dout_s;
    logic              mem_wr_r, mem_wr_s;
    logic              f_ren_r, f_ren_s;
    logic              f_de_r, f_de_s;
    logic [31:0]       f_inst_r, f_inst_s;
    logic              l_ren_r, l_ren_s;
    logic              l_de_r, l_de_s;
    logic [31:0]       l_rdata_r, l_rdata_s;
    logic              rdy_q_r;
    logic [7:0]        din_hold_r;
    logic [7:0]        byte_s;
    logic [2:0]        cap_k_s;
    logic [ADDR_W-1:0] idx_addr_s;

    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] k,
                                             input logic [7:0] b);
        logic [31:0] w;
        w = word;
        case (k)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            2'd3:    w[31:24] = b;
            default: w        = word;
        endcase
        return w;
    endfunction

    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    function automatic logic io_blocked(input logic [1:0] region, input logic full);
        return full && (region == IO_BASE_HI);
    endfunction

    function automatic logic [2:0] size_to_len(input logic [2:0] size);
        logic [2:0] len;
        case (size)
            3'd1:    len = 3'd1;
            3'd2:    len = 3'd2;
            default: len = 3'd4;
        endcase
        return len;
    endfunction

    // While stalled, the RAM keeps answering the held address, so the byte
    // due at the first stalled edge is parked here and consumed on resume.
    assign byte_s     = rdy_q_r ? bus.in_mem_din : din_hold_r;
    assign cap_k_s    = idx_r - 3'd2;
    assign idx_addr_s = cur_base_r + {{(ADDR_W-3){1'b0}}, idx_r};

    // Slot capture, scheduling and byte sequencing.
    always_comb begin
        state_s       = state_r;
        fslot_vld_s   = fslot_vld_r;
        fslot_addr_s  = fslot_addr_r;
        lslot_vld_s   = lslot_vld_r;
        lslot_rw_s    = lslot_rw_r;
        lslot_len_s   = lslot_len_r;
        lslot_addr_s  = lslot_addr_r;
        lslot_wdata_s = lslot_wdata_r;
        cur_fetch_s   = cur_fetch_r;
        cur_base_s    = cur_base_r;
        cur_len_s     = cur_len_r;
        cur_wdata_s   = cur_wdata_r;
        idx_s         = idx_r;
        asm_s         = asm_r;
        mem_addr_s    = mem_addr_r;
        mem_dout_s    = mem_dout_r;
        mem_wr_s      = 1'b0;
        f_de_s        = 1'b0;
        f_inst_s      = f_inst_r;
        l_de_s        = 1'b0;
        l_rdata_s     = l_rdata_r;

        if (bus.in_fetcher_requesting && f_ren_r && !bus.in_flush_enable) begin
            fslot_vld_s  = 1'b1;
            fslot_addr_s = bus.in_fetcher_addr;
        end else if (bus.in_flush_enable) begin
            fslot_vld_s = 1'b0;
        end else begin
            fslot_vld_s = fslot_vld_r;
        end

        if (bus.in_lsu_requesting && l_ren_r) begin
            lslot_vld_s   = 1'b1;
            lslot_rw_s    = bus.in_lsu_rw;
            lslot_len_s   = size_to_len(bus.in_lsu_size);
            lslot_addr_s  = bus.in_lsu_addr;
            lslot_wdata_s = bus.in_lsu_wdata;
        end else begin
            lslot_vld_s = lslot_vld_r;
        end

        case (state_r)
            IDLE: begin
                if (lslot_vld_r) begin
                    lslot_vld_s = 1'b0;
                    cur_fetch_s = 1'b0;
                    cur_base_s  = lslot_addr_r;
                    cur_len_s   = lslot_len_r;
                    cur_wdata_s = lslot_wdata_r;
                    asm_s       = 32'd0;
                    mem_addr_s  = lslot_addr_r;
                    if (!lslot_rw_r) begin
                        state_s = READ;
                        idx_s   = 3'd1;
                    end else if (io_blocked(lslot_addr_r[17:16], bus.in_io_buffer_full)) begin
                        state_s = WRITE;
                        idx_s   = 3'd0;
                    end else begin
                        state_s    = WRITE;
                        idx_s      = 3'd1;
                        mem_dout_s = lslot_wdata_r[7:0];
                        mem_wr_s   = 1'b1;
                    end
                end else if (fslot_vld_r && !bus.in_flush_enable) begin
                    fslot_vld_s = 1'b0;
                    cur_fetch_s = 1'b1;
                    cur_base_s  = fslot_addr_r;
                    cur_len_s   = 3'd4;
                    asm_s       = 32'd0;
                    mem_addr_s  = fslot_addr_r;
                    idx_s       = 3'd1;
                    state_s     = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (cur_fetch_r && bus.in_flush_enable) begin
                    state_s = IDLE;
                end else begin
                    if (idx_r < cur_len_r) begin
                        mem_addr_s = idx_addr_s;
                    end else begin
                        mem_addr_s = mem_addr_r;
                    end
                    if (idx_r >= 3'd2) begin
                        asm_s = put_byte(asm_r, cap_k_s[1:0], byte_s);
                    end else begin
                        asm_s = asm_r;
                    end
                    if (idx_r == (cur_len_r + 3'd1)) begin
                        state_s = IDLE;
                        if (cur_fetch_r) begin
                            f_de_s   = 1'b1;
                            f_inst_s = asm_s;
                        end else begin
                            l_de_s    = 1'b1;
                            l_rdata_s = asm_s;
                        end
                    end else begin
                        state_s = READ;
                    end
                    idx_s = idx_r + 3'd1;
                end
            end
            WRITE: begin
                if (idx_r == cur_len_r) begin
                    state_s = IDLE;
                    l_de_s  = 1'b1;
                end else if (io_blocked(idx_addr_s[17:16], bus.in_io_buffer_full)) begin
                    mem_addr_s = idx_addr_s;
                end else begin
                    mem_addr_s = idx_addr_s;
                    mem_dout_s = pick_byte(cur_wdata_r, idx_r[1:0]);
                    mem_wr_s   = 1'b1;
                    idx_s      = idx_r + 3'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        f_ren_s = !fslot_vld_s && !((state_s == READ) && cur_fetch_s);
        l_ren_s = !lslot_vld_s && !((state_s != IDLE) && !cur_fetch_s);
    end

    // Dispatcher state and registered outputs; frozen while in_rdy is low.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_r       <= IDLE;
            fslot_vld_r   <= 1'b0;
            fslot_addr_r  <= {ADDR_W{1'b0}};
            lslot_vld_r   <= 1'b0;
            lslot_rw_r    <= 1'b0;
            lslot_len_r   <= 3'd0;
            lslot_addr_r  <= {ADDR_W{1'b0}};
            lslot_wdata_r <= 32'd0;
            cur_fetch_r   <= 1'b0;
            cur_base_r    <= {ADDR_W{1'b0}};
            cur_len_r     <= 3'd0;
            cur_wdata_r   <= 32'd0;
            idx_r         <= 3'd0;
            asm_r         <= 32'd0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            mem_dout_r    <= 8'd0;
            mem_wr_r      <= 1'b0;
            f_ren_r       <= 1'b0;
            f_de_r        <= 1'b0;
            f_inst_r      <= 32'd0;
            l_ren_r       <= 1'b0;
            l_de_r        <= 1'b0;
            l_rdata_r     <= 32'd0;
        end else if (in_rdy) begin
            state_r       <= state_s;
            fslot_vld_r   <= fslot_vld_s;
            fslot_addr_r  <= fslot_addr_s;
            lslot_vld_r   <= lslot_vld_s;
            lslot_rw_r    <= lslot_rw_s;
            lslot_len_r   <= lslot_len_s;
            lslot_addr_r  <= lslot_addr_s;
            lslot_wdata_r <= lslot_wdata_s;
            cur_fetch_r   <= cur_fetch_s;
            cur_base_r    <= cur_base_s;
            cur_len_r     <= cur_len_s;
            cur_wdata_r   <= cur_wdata_s;
            idx_r         <= idx_s;
            asm_r         <= asm_s;
            mem_addr_r    <= mem_addr_s;
            mem_dout_r    <= mem_dout_s;
            mem_wr_r      <= mem_wr_s;
            f_ren_r       <= f_ren_s;
            f_de_r        <= f_de_s;
            f_inst_r      <= f_inst_s;
            l_ren_r       <= l_ren_s;
            l_de_r        <= l_de_s;
            l_rdata_r     <= l_rdata_s;
        end
    end

    // Tracks in_rdy and parks the RAM byte at the onset of a stall.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            rdy_q_r    <= 1'b1;
            din_hold_r <= 8'd0;
        end else begin
            rdy_q_r <= in_rdy;
            if (rdy_q_r && !in_rdy) begin
                din_hold_r <= bus.in_mem_din;
            end
        end
    end

    assign bus.out_fetcher_req_enable  = f_ren_r;
    assign bus.out_fetcher_data_enable = f_de_r;
    assign bus.out_fetcher_inst        = f_inst_r;
    assign bus.out_lsu_req_enable      = l_ren_r;
    assign bus.out_lsu_data_enable     = l_de_r;
    assign bus.out_lsu_rdata           = l_rdata_r;
    assign bus.out_mem_addr            = mem_addr_r;
    assign bus.out_mem_dout            = mem_dout_r;
    assign bus.out_mem_wr              = mem_wr_r;

endmodule

// File: tb/tb_mem_dispatcher.sv
// Directed bench for mem_dispatcher against a synchronous byte RAM model.
`timescale 1ns/1ps
module tb_mem_dispatcher;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    always #5 clk = ~clk;

    mem_dispatcher_if #(.ADDR_W(32)) bus ();

    mem_dispatcher #(.ADDR_W(32), .IO_BASE_HI(2'b11)) dut (
        .in_clk (clk),
        .in_rst (rst),
        .in_rdy (rdy),
        .bus    (bus)
    );

    logic [7:0]  ram [0:262143];
    logic        pl_we;
    logic [17:0] pl_addr;
    logic [7:0]  pl_data;
    int          wr_cnt;

    // RAM answers the address it samples one edge later; preload port for setup.
    always @(posedge clk) begin
        if (rst) begin
            wr_cnt <= 0;
        end else if (bus.out_mem_wr === 1'b1) begin
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.out_mem_wr === 1'b1) begin
            ram[bus.out_mem_addr[17:0]] <= bus.out_mem_dout;
        end else if (pl_we) begin
            ram[pl_addr] <= pl_data;
        end
        bus.in_mem_din <= ram[bus.out_mem_addr[17:0]];
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preload(input logic [17:0] a, input logic [7:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_we   = 1'b0;
    endtask

    task automatic fetch_pulse(input logic [31:0] a);
        bus.in_fetcher_requesting = 1'b1;
        bus.in_fetcher_addr       = a;
        tick();
        bus.in_fetcher_requesting = 1'b0;
    endtask

    task automatic lsu_pulse(input logic rw, input logic [2:0] sz, input logic [31:0] a,
                             input logic [31:0] wd);
        bus.in_lsu_requesting = 1'b1;
        bus.in_lsu_rw         = rw;
        bus.in_lsu_size       = sz;
        bus.in_lsu_addr       = a;
        bus.in_lsu_wdata      = wd;
        tick();
        bus.in_lsu_requesting = 1'b0;
    endtask

    task automatic wait_pulse(input logic lsu, input int budget, output int lat,
                              output logic [31:0] word);
        lat  = -1;
        word = 32'd0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (lsu && bus.out_lsu_data_enable === 1'b1) begin
                lat  = i;
                word = bus.out_lsu_rdata;
                break;
            end else if (!lsu && bus.out_fetcher_data_enable === 1'b1) begin
                lat  = i;
                word = bus.out_fetcher_inst;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int          lat, f_lat, l_lat, f_cnt, l_cnt, w0;
        logic [31:0] word, f_word, l_word, wd;

        rst = 1'b1;
        rdy = 1'b1;
        pl_we = 1'b0;
        pl_addr = 18'd0;
        pl_data = 8'd0;
        bus.in_flush_enable       = 1'b0;
        bus.in_fetcher_requesting = 1'b0;
        bus.in_fetcher_addr       = 32'd0;
        bus.in_lsu_requesting     = 1'b0;
        bus.in_lsu_rw             = 1'b0;
        bus.in_lsu_size           = 3'd0;
        bus.in_lsu_addr           = 32'd0;
        bus.in_lsu_wdata          = 32'd0;
        bus.in_io_buffer_full     = 1'b0;
        @(negedge clk);
        preload(18'h01000, 8'h13); preload(18'h01001, 8'h05);
        preload(18'h01002, 8'h00); preload(18'h01003, 8'h00);
        preload(18'h02000, 8'h93); preload(18'h02001, 8'h00);
        preload(18'h02002, 8'h10); preload(18'h02003, 8'h00);
        preload(18'h03000, 8'h11); preload(18'h03001, 8'h22);
        preload(18'h03002, 8'h33); preload(18'h03003, 8'h44);
        preload(18'h00040, 8'h34); preload(18'h00041, 8'h12);

        check_val("rst_f_ren",  32'(bus.out_fetcher_req_enable), 32'd0);
        check_val("rst_l_ren",  32'(bus.out_lsu_req_enable), 32'd0);
        check_val("rst_f_de",   32'(bus.out_fetcher_data_enable), 32'd0);
        check_val("rst_l_de",   32'(bus.out_lsu_data_enable), 32'd0);
        check_val("rst_inst",   bus.out_fetcher_inst, 32'd0);
        check_val("rst_rdata",  bus.out_lsu_rdata, 32'd0);
        check_val("rst_addr",   bus.out_mem_addr, 32'd0);
        check_val("rst_dout",   32'(bus.out_mem_dout), 32'd0);
        check_val("rst_wr",     32'(bus.out_mem_wr), 32'd0);
        rst = 1'b0;
        tick();
        check_val("idle_f_ren", 32'(bus.out_fetcher_req_enable), 32'd1);
        check_val("idle_l_ren", 32'(bus.out_lsu_req_enable), 32'd1);

        // Plain fetch
        w0 = wr_cnt;
        fetch_pulse(32'h0000_1000);
        wait_pulse(1'b0, 12, lat, word);
        check_val("fetch_lat",  32'(lat), 32'd6);
        check_val("fetch_inst", word, 32'h0000_0513);
        tick();
        check_val("fetch_width", 32'(bus.out_fetcher_data_enable), 32'd0);
        check_val("fetch_no_wr", 32'(wr_cnt - w0), 32'd0);
        check_val("fetch_ren_back", 32'(bus.out_fetcher_req_enable), 32'd1);

        // Word store, byte by byte
        wd = 32'hDEAD_BEEF;
        lsu_pulse(1'b1, 3'd4, 32'h0000_0020, wd);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("st_wr",   32'(bus.out_mem_wr), 32'd1);
            check_val("st_addr", bus.out_mem_addr, 32'h20 + 32'(k));
            check_val("st_byte", 32'(bus.out_mem_dout), 32'(wd[8*k +: 8]));
        end
        tick();
        check_val("st_wr_end", 32'(bus.out_mem_wr), 32'd0);
        check_val("st_done",   32'(bus.out_lsu_data_enable), 32'd1);
        tick();
        check_val("st_width",  32'(bus.out_lsu_data_enable), 32'd0);
        lsu_pulse(1'b0, 3'd4, 32'h0000_0020, 32'd0);
        wait_pulse(1'b1, 12, lat, word);
        check_val("ld_lat",  32'(lat), 32'd6);
        check_val("ld_data", word, 32'hDEAD_BEEF);
        tick();

        // Simultaneous fetch and half-word load
        bus.in_fetcher_requesting = 1'b1;
        bus.in_fetcher_addr       = 32'h0000_2000;
        bus.in_lsu_requesting     = 1'b1;
        bus.in_lsu_rw             = 1'b0;
        bus.in_lsu_size           = 3'd2;
        bus.in_lsu_addr           = 32'h0000_0040;
        tick();
        bus.in_fetcher_requesting = 1'b0;
        bus.in_lsu_requesting     = 1'b0;
        f_lat = -1; l_lat = -1; f_cnt = 0; l_cnt = 0; f_word = 32'd0; l_word = 32'd0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.out_lsu_data_enable === 1'b1) begin
                l_cnt++;
                if (l_lat < 0) begin l_lat = i; l_word = bus.out_lsu_rdata; end
            end
            if (bus.out_fetcher_data_enable === 1'b1) begin
                f_cnt++;
                if (f_lat < 0) begin f_lat = i; f_word = bus.out_fetcher_inst; end
            end
        end
        check_val("both_l_lat",  32'(l_lat), 32'd4);
        check_val("both_l_data", l_word, 32'h0000_1234);
        check_val("both_f_lat",  32'(f_lat), 32'd10);
        check_val("both_f_inst", f_word, 32'h0010_0093);
        check_val("both_l_cnt",  32'(l_cnt), 32'd1);
        check_val("both_f_cnt",  32'(f_cnt), 32'd1);

        // Flush two edges into a fetch
        fetch_pulse(32'h0000_1000);
        tick();
        bus.in_flush_enable = 1'b1;
        tick();
        bus.in_flush_enable = 1'b0;
        check_val("flush_idle", 32'(bus.out_fetcher_req_enable), 32'd1);
        f_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_fetcher_data_enable === 1'b1) f_cnt++;
        end
        check_val("flush_no_de", 32'(f_cnt), 32'd0);
        fetch_pulse(32'h0000_2000);
        wait_pulse(1'b0, 12, lat, word);
        check_val("flush_refetch_lat",  32'(lat), 32'd6);
        check_val("flush_refetch_inst", word, 32'h0010_0093);

        // Byte store into the IO region while the buffer is full
        bus.in_io_buffer_full = 1'b1;
        w0 = wr_cnt;
        lsu_pulse(1'b1, 3'd1, 32'h0003_0000, 32'h0000_00A5);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("io_hold_wr", 32'(bus.out_mem_wr), 32'd0);
        end
        bus.in_io_buffer_full = 1'b0;
        tick();
        check_val("io_wr",   32'(bus.out_mem_wr), 32'd1);
        check_val("io_addr", bus.out_mem_addr, 32'h0003_0000);
        check_val("io_byte", 32'(bus.out_mem_dout), 32'h0000_00A5);
        tick();
        check_val("io_done", 32'(bus.out_lsu_data_enable), 32'd1);
        tick();
        tick();
        check_val("io_wr_count", 32'(wr_cnt - w0), 32'd1);

        // Two-cycle stall in the middle of a fetch
        fetch_pulse(32'h0000_3000);
        tick(); tick(); tick();
        check_val("stall_pre_addr", bus.out_mem_addr, 32'h0000_3002);
        rdy = 1'b0;
        tick(); tick();
        check_val("stall_hold_addr", bus.out_mem_addr, 32'h0000_3002);
        check_val("stall_no_de", 32'(bus.out_fetcher_data_enable), 32'd0);
        rdy = 1'b1;
        wait_pulse(1'b0, 12, lat, word);
        check_val("stall_lat",  32'(lat + 5), 32'd8);
        check_val("stall_inst", word, 32'h4433_2211);
        tick();

        // Reset in the middle of a store
        lsu_pulse(1'b1, 3'd4, 32'h0000_0050, 32'h0102_0304);
        tick(); tick();
        check_val("mid_wr", 32'(bus.out_mem_wr), 32'd1);
        rst = 1'b1;
        tick();
        check_val("mid_rst_wr",    32'(bus.out_mem_wr), 32'd0);
        check_val("mid_rst_l_ren", 32'(bus.out_lsu_req_enable), 32'd0);
        rst = 1'b0;
        tick();
        check_val("mid_rel_l_ren", 32'(bus.out_lsu_req_enable), 32'd1);
        check_val("mid_rel_f_ren", 32'(bus.out_fetcher_req_enable), 32'd1);
        l_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_lsu_data_enable === 1'b1) l_cnt++;
        end
        check_val("mid_no_de",  32'(l_cnt), 32'd0);
        check_val("mid_no_wr",  32'(wr_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
